// File: rtl/player_walk_controller_if.sv
// rtl/player_walk_controller_if.sv - Key/tick inputs and sprite/scroll outputs of the walk controller.
// WALK_RUN_EN adds the key_run input.
interface player_walk_controller_if;
  logic       frame_tick;
  logic       key_valid;
  logic [1:0] key_dir;
  logic       blocked;
`ifdef WALK_RUN_EN
  logic       key_run;
`endif
  logic [1:0] Direction;
  logic       Character_Moving;
  logic [1:0] Anim_Phase;
  logic [9:0] Map_X;
  logic [9:0] Map_Y;
  logic       step_done;

`ifdef WALK_RUN_EN
  modport master (
    output frame_tick, key_valid, key_dir, blocked, key_run,
    input  Direction, Character_Moving, Anim_Phase, Map_X, Map_Y, step_done
  );
  modport slave (
    input  frame_tick, key_valid, key_dir, blocked, key_run,
    output Direction, Character_Moving, Anim_Phase, Map_X, Map_Y, step_done
  );
`else
  modport master (
    output frame_tick, key_valid, key_dir, blocked,
    input  Direction, Character_Moving, Anim_Phase, Map_X, Map_Y, step_done
  );
  modport slave (
    input  frame_tick, key_valid, key_dir, blocked,
    output Direction, Character_Moving, Anim_Phase, Map_X, Map_Y, step_done
  );
`endif
endinterface

// File: rtl/player_walk_controller.sv
// rtl/player_walk_controller.sv - Tile-grid player walk sequencer: turn, walk or bump one tile per key hold.
// Defining WALK_RUN_EN adds key_run, which doubles the per-tick pixel stride for the whole step.
module player_walk_controller #(
  parameter int         STEP_PX    = 16,
  parameter int         TURN_TICKS = 4,
  parameter logic [9:0] START_X    = 10'd0,
  parameter logic [9:0] START_Y    = 10'd0
) (
  input logic                     Clk,
  input logic                     Reset,
  player_walk_controller_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TURN = 2'd1;
  localparam logic [1:0] S_WALK = 2'd2;
  localparam logic [1:0] S_BUMP = 2'd3;
  localparam int PW = $clog2(STEP_PX) + 1;
  localparam int TW = $clog2(TURN_TICKS + 1);

  logic [1:0]    r_state;
  logic [1:0]    r_dir;
  logic [1:0]    r_anim;
  logic [9:0]    r_map_x;
  logic [9:0]    r_map_y;
  logic [PW-1:0] r_px_cnt;
  logic [TW-1:0] r_tick_cnt;
  logic          r_step_done;

  logic [PW-1:0] w_stride;
  logic [PW-1:0] w_px_next;
  logic [9:0]    w_delta;
  logic [9:0]    w_x_next;
  logic [9:0]    w_y_next;
  logic [1:0]    w_anim_next;
  logic [1:0]    w_step_state;
  logic          w_anim_adv;
  logic          w_same_dir;
  logic          w_turn_last;
  logic          w_moving;
  logic          w_step_end;
  logic          w_start;

`ifdef WALK_RUN_EN
  logic r_run;
  assign w_stride = r_run ? PW'(2) : PW'(1);

  // Run mode is latched at every step start so a step never changes speed midway.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_run <= 1'b0;
    end else if (w_start) begin
      r_run <= bus.key_run;
    end
  end
`else
  assign w_stride = PW'(1);
`endif

  assign w_px_next    = r_px_cnt + w_stride;
  assign w_delta      = 10'(w_stride);
  assign w_same_dir   = bus.key_valid && (bus.key_dir == r_dir);
  assign w_turn_last  = (r_tick_cnt == TW'(TURN_TICKS - 1));
  assign w_moving     = (r_state == S_WALK) || (r_state == S_BUMP);
  assign w_step_end   = (w_px_next == PW'(STEP_PX));
  assign w_step_state = bus.blocked ? S_BUMP : S_WALK;
  assign w_anim_adv   = (r_px_cnt == '0) || (w_px_next == PW'(STEP_PX / 2));
  assign w_anim_next  = r_anim + {1'b0, w_anim_adv};

  // A step starts from IDLE, at the end of a turn, or chained off a finished step (walk only).
  assign w_start = bus.frame_tick && w_same_dir &&
                   ((r_state == S_IDLE) ||
                    ((r_state == S_TURN) && w_turn_last) ||
                    (w_moving && w_step_end && !bus.blocked));

  always_comb begin
    w_x_next = r_map_x;
    w_y_next = r_map_y;
    case (r_dir)
      2'd0:    w_y_next = r_map_y - w_delta;
      2'd1:    w_x_next = r_map_x + w_delta;
      2'd2:    w_y_next = r_map_y + w_delta;
      default: w_x_next = r_map_x - w_delta;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_dir       <= 2'd0;
      r_anim      <= 2'd0;
      r_map_x     <= START_X;
      r_map_y     <= START_Y;
      r_px_cnt    <= '0;
      r_tick_cnt  <= '0;
      r_step_done <= 1'b0;
    end else begin
      r_step_done <= 1'b0;
      if (bus.frame_tick) begin
        if (r_state == S_TURN) begin
          r_tick_cnt <= r_tick_cnt + 1'b1;
        end
        if (w_moving) begin
          r_px_cnt <= w_px_next;
          r_anim   <= w_anim_next;
          if (r_state == S_WALK) begin
            r_map_x <= w_x_next;
            r_map_y <= w_y_next;
          end
          if (w_step_end) begin
            r_step_done <= (r_state == S_WALK);
            if (!w_start) begin
              r_state <= S_IDLE;
              if (w_anim_next[0]) begin
                r_anim <= 2'd0;
              end
            end
          end
        end
        if ((r_state == S_IDLE) && bus.key_valid && !w_same_dir) begin
          r_dir      <= bus.key_dir;
          r_state    <= S_TURN;
          r_tick_cnt <= '0;
        end
        if ((r_state == S_TURN) && w_turn_last && !w_same_dir) begin
          r_state <= S_IDLE;
        end
        if (w_start) begin
          r_state  <= w_step_state;
          r_px_cnt <= '0;
        end
      end
    end
  end

  assign bus.Direction        = r_dir;
  assign bus.Character_Moving = w_moving;
  assign bus.Anim_Phase       = r_anim;
  assign bus.Map_X            = r_map_x;
  assign bus.Map_Y            = r_map_y;
  assign bus.step_done        = r_step_done;
endmodule

// File: tb/tb_player_walk_controller.sv
// tb/tb_player_walk_controller.sv - Self-checking bench for player_walk_controller against a tile-step model.
module tb_player_walk_controller;
  localparam int         STEP_PX    = 16;
  localparam int         TURN_TICKS = 4;
  localparam logic [9:0] SX         = 10'd100;
  localparam logic [9:0] SY         = 10'd0;

  logic Clk = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  player_walk_controller_if bus ();

  player_walk_controller #(
    .STEP_PX   (STEP_PX),
    .TURN_TICKS(TURN_TICKS),
    .START_X   (SX),
    .START_Y   (SY)
  ) u_dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  typedef enum int {M_REST, M_FACING, M_STEP} mmode_t;
  mmode_t m_mode;
  int     m_dir, m_x, m_y, m_anim, m_px, m_turn_left, m_done;
  bit     m_walk;

  task automatic m_begin_step(input bit walk);
    m_mode = M_STEP;
    m_walk = walk;
    m_px   = 0;
  endtask

  // Behavioural model: one call per clock edge, using the inputs held across that edge.
  task automatic model_clock();
    bit kv;
    int kd;
    bit bl;
    kv = bus.key_valid;
    kd = int'(bus.key_dir);
    bl = bus.blocked;
    m_done = 0;
    if (Reset) begin
      m_mode = M_REST; m_dir = 0; m_anim = 0; m_x = SX; m_y = SY; m_px = 0; m_turn_left = 0;
      return;
    end
    if (!bus.frame_tick) return;
    case (m_mode)
      M_REST: begin
        if (kv) begin
          if (kd != m_dir) begin
            m_dir = kd; m_mode = M_FACING; m_turn_left = TURN_TICKS;
          end else begin
            m_begin_step(!bl);
          end
        end
      end
      M_FACING: begin
        m_turn_left--;
        if (m_turn_left == 0) begin
          if (kv && kd == m_dir) m_begin_step(!bl);
          else m_mode = M_REST;
        end
      end
      default: begin
        m_px++;
        if (m_walk) begin
          case (m_dir)
            0: m_y = (m_y + 1023) % 1024;
            1: m_x = (m_x + 1) % 1024;
            2: m_y = (m_y + 1) % 1024;
            default: m_x = (m_x + 1023) % 1024;
          endcase
        end
        if (m_px == 1 || m_px == STEP_PX / 2) m_anim = (m_anim + 1) % 4;
        if (m_px == STEP_PX) begin
          if (m_walk) m_done = 1;
          if (kv && kd == m_dir && !bl) begin
            m_begin_step(1'b1);
          end else begin
            m_mode = M_REST;
            if (m_anim % 2 == 1) m_anim = 0;
          end
        end
      end
    endcase
  endtask

  function automatic logic [25:0] exp_vec();
    return {2'(m_dir), (m_mode == M_STEP), 2'(m_anim), 10'(m_x), 10'(m_y), (m_done != 0)};
  endfunction

  function automatic logic [25:0] dut_vec();
    return {bus.Direction, bus.Character_Moving, bus.Anim_Phase, bus.Map_X, bus.Map_Y, bus.step_done};
  endfunction

  task automatic clk_cycle();
    @(posedge Clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.frame_tick = 1'b0;
    clk_cycle();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.frame_tick = 1'b1; bus.key_valid = 1'b1; bus.key_dir = 2'd2; bus.blocked = 1'b0;
    clk_cycle();
    n_checks++;
    if (dut_vec() !== {2'd0, 1'b0, 2'd0, SX, SY, 1'b0}) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec(), {2'd0, 1'b0, 2'd0, SX, SY, 1'b0});
    end
    clk_cycle();
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_hold: got %h expected %h", dut_vec(), exp_vec());
    end
    Reset = 1'b0;
    bus.frame_tick = 1'b0; bus.key_valid = 1'b0;
  endtask

  task automatic test_turn_walk();
    int pulses = 0;
    do_reset();
    bus.key_valid = 1'b1; bus.key_dir = 2'd1; bus.blocked = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      if (t == 15) bus.key_valid = 1'b0;
      bus.frame_tick = 1'b1; clk_cycle(); bus.frame_tick = 1'b0;
      pulses += int'(bus.step_done);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL turn_walk t=%0d: got %h expected %h", t, dut_vec(), exp_vec());
      end
      if (t <= 4) begin
        n_checks++;
        if (bus.Map_X !== SX || bus.Character_Moving !== 1'b0 || bus.Direction !== 2'd1) begin
          n_fail++; $display("FAIL turn_phase t=%0d: x=%0d mov=%b dir=%0d expected x=%0d mov=0 dir=1", t, bus.Map_X, bus.Character_Moving, bus.Direction, SX);
        end
      end
      if (t == 6 || t == 13) begin
        n_checks++;
        if (bus.Anim_Phase !== ((t == 6) ? 2'd1 : 2'd2)) begin
          n_fail++; $display("FAIL walk_anim t=%0d: got %0d expected %0d", t, bus.Anim_Phase, (t == 6) ? 1 : 2);
        end
      end
      clk_cycle();
      pulses += int'(bus.step_done);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL turn_walk_gap t=%0d: got %h expected %h", t, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (bus.Map_X !== SX + 10'd16 || bus.Anim_Phase !== 2'd2 || bus.Character_Moving !== 1'b0 || pulses != 1) begin
      n_fail++; $display("FAIL turn_walk_end: x=%0d anim=%0d mov=%b pulses=%0d expected x=%0d anim=2 mov=0 pulses=1", bus.Map_X, bus.Anim_Phase, bus.Character_Moving, pulses, SX + 10'd16);
    end
  endtask

  task automatic test_continuous();
    int pulses = 0;
    do_reset();
    bus.key_valid = 1'b1; bus.key_dir = 2'd2; bus.blocked = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      if (t == 41) bus.key_valid = 1'b0;
      bus.frame_tick = 1'b1; clk_cycle(); bus.frame_tick = 1'b0;
      if (t <= 40) pulses += int'(bus.step_done);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL continuous t=%0d: got %h expected %h", t, dut_vec(), exp_vec());
      end
      if (t >= 5 && t <= 40) begin
        n_checks++;
        if (bus.Character_Moving !== 1'b1) begin
          n_fail++; $display("FAIL continuous_gap t=%0d: moving=%b expected 1", t, bus.Character_Moving);
        end
      end
      if (t == 37) begin
        n_checks++;
        if (bus.Map_Y !== SY + 10'd32 || bus.Anim_Phase !== 2'd0) begin
          n_fail++; $display("FAIL continuous_two_steps: y=%0d anim=%0d expected y=%0d anim=0", bus.Map_Y, bus.Anim_Phase, SY + 10'd32);
        end
      end
      clk_cycle();
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++; $display("FAIL continuous_pulses: got %0d expected 2", pulses);
    end
  endtask

  task automatic test_blocked();
    int pulses = 0;
    int moving = 0;
    do_reset();
    bus.key_valid = 1'b1; bus.key_dir = 2'd0; bus.blocked = 1'b1;
    for (int t = 1; t <= 36; t++) begin
      bus.frame_tick = 1'b1; clk_cycle(); bus.frame_tick = 1'b0;
      pulses += int'(bus.step_done);
      if (t <= 17) moving += int'(bus.Character_Moving);
      n_checks++;
      if (dut_vec() !== exp_vec() || bus.Map_Y !== SY) begin
        n_fail++; $display("FAIL blocked t=%0d: got %h expected %h", t, dut_vec(), exp_vec());
      end
      if (t == 18) begin
        n_checks++;
        if (moving != 16 || bus.Character_Moving !== 1'b1) begin
          n_fail++; $display("FAIL bump_length: moving ticks=%0d rebump=%b expected 16 and 1", moving, bus.Character_Moving);
        end
      end
      clk_cycle();
      pulses += int'(bus.step_done);
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL bump_step_done: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_early_release();
    do_reset();
    bus.key_valid = 1'b1; bus.key_dir = 2'd3; bus.blocked = 1'b0;
    for (int t = 1; t <= 125; t++) begin
      if (t == 105) bus.key_valid = 1'b0;
      bus.frame_tick = 1'b1; clk_cycle(); bus.frame_tick = 1'b0;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL early_release t=%0d: got %h expected %h", t, dut_vec(), exp_vec());
      end
      clk_cycle();
    end
    n_checks++;
    if (bus.Map_X !== 10'd1012 || bus.Character_Moving !== 1'b0) begin
      n_fail++; $display("FAIL early_release_wrap: x=%0d mov=%b expected x=1012 mov=0", bus.Map_X, bus.Character_Moving);
    end
  endtask

  task automatic test_reset_mid_step();
    do_reset();
    bus.key_valid = 1'b1; bus.key_dir = 2'd1; bus.blocked = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      bus.frame_tick = 1'b1; clk_cycle(); bus.frame_tick = 1'b0;
      clk_cycle();
    end
    n_checks++;
    if (bus.Map_X !== SX + 10'd7 || bus.Character_Moving !== 1'b1) begin
      n_fail++; $display("FAIL mid_step_pos: x=%0d mov=%b expected x=%0d mov=1", bus.Map_X, bus.Character_Moving, SX + 10'd7);
    end
    Reset = 1'b1; bus.frame_tick = 1'b1;
    clk_cycle();
    Reset = 1'b0; bus.frame_tick = 1'b0;
    n_checks++;
    if (dut_vec() !== {2'd0, 1'b0, 2'd0, SX, SY, 1'b0} || dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_mid_step: got %h expected %h", dut_vec(), {2'd0, 1'b0, 2'd0, SX, SY, 1'b0});
    end
  endtask

  task automatic test_no_tick();
    do_reset();
    bus.key_valid = 1'b1; bus.key_dir = 2'd1; bus.blocked = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      bus.frame_tick = 1'b1; clk_cycle(); bus.frame_tick = 1'b0;
    end
    for (int c = 0; c < 1000; c++) begin
      bus.key_valid = 1'($urandom_range(0, 1));
      bus.key_dir   = 2'($urandom_range(0, 3));
      bus.blocked   = 1'($urandom_range(0, 1));
      clk_cycle();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL no_tick c=%0d: got %h expected %h", c, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (bus.Map_X !== SX + 10'd5) begin
      n_fail++; $display("FAIL no_tick_pos: x=%0d expected %0d", bus.Map_X, SX + 10'd5);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      Reset          = ($urandom_range(0, 599) == 0);
      bus.frame_tick = ($urandom_range(0, 2) == 0);
      bus.key_valid  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) bus.key_dir = 2'($urandom_range(0, 3));
      bus.blocked    = ($urandom_range(0, 3) == 0);
      clk_cycle();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random c=%0d: got %h expected %h", c, dut_vec(), exp_vec());
      end
    end
    Reset = 1'b0;
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    bus.frame_tick = 1'b0; bus.key_valid = 1'b0; bus.key_dir = 2'd0; bus.blocked = 1'b0;
`ifdef WALK_RUN_EN
    bus.key_run = 1'b0;
`endif
    test_reset();
    test_turn_walk();
    test_continuous();
    test_blocked();
    test_early_release();
    test_reset_mid_step();
    test_no_tick();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/player_walk_controller.md
Name: player_walk_controller

Overview:
- Tile-grid movement sequencer for the overworld player sprite.
- Converts held-key direction requests into one tile step at a time. The player turns in place first, walks only if the target tile is clear, and bumps in place if it is blocked.
- Drives the sprite renderer's Direction / Character_Moving inputs, a 2-bit walk animation phase, and the world scroll offsets Map_X / Map_Y.
- Advances only on frame_tick, the one-cycle vertical-sync pulse. Sits between the keyboard decode and the color mapper / map renderer.

Parameters:
STEP_PX, 16, pixels per tile step; power of two, >= 4
TURN_TICKS, 4, frame ticks spent facing a new direction before a step can start
START_X, 10'd0, Map_X reset value
START_Y, 10'd0, Map_Y reset value

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-Clk pulse per video frame (VS edge)
key_valid  in  1  a direction key is held
key_dir  in  2  held direction: 0 up, 1 right, 2 down, 3 left
blocked  in  1  target tile in key_dir is impassable; valid combinationally in the same cycle as key_dir
Direction  out  2  facing direction, same encoding as key_dir
Character_Moving  out  1  high in WALK and BUMP
Anim_Phase  out  2  walk frame: 0 rest1, 1 move1, 2 rest2, 3 move2
Map_X  out  10  world scroll X, wraps mod 1024
Map_Y  out  10  world scroll Y, wraps mod 1024
step_done  out  1  one-Clk pulse when a WALK step completes

Behaviour:
Reset:
- State IDLE; Direction=0; Character_Moving=0; Anim_Phase=0.
- Map_X=START_X; Map_Y=START_Y; step_done=0.
- All counters cleared.
- Reset overrides every other input and aborts any step mid-flight. Position is not rounded to a tile.

General timing:
- All state changes occur only in cycles where frame_tick=1, except Reset and the step_done clear.
- step_done is high for exactly one Clk, in the cycle after the final WALK tick.

Decision rule, evaluated at a frame_tick in IDLE:
- key_valid=0: stay IDLE.
- key_dir != Direction: Direction<=key_dir; go to TURN; tick_cnt<=0.
- Otherwise, blocked=0: go to WALK; px_cnt<=0.
- Otherwise, blocked=1: go to BUMP; px_cnt<=0.

TURN:
- Each tick increments tick_cnt. Character_Moving stays 0.
- At tick_cnt==TURN_TICKS-1, re-evaluate the decision rule:
  - key released or different direction: go to IDLE (a different direction then turns again on the next IDLE tick).
  - same direction: WALK or BUMP per blocked.

WALK, each tick:
- px_cnt++.
- Move 1 px in Direction: up Map_Y-1, right Map_X+1, down Map_Y+1, left Map_X-1, all 10-bit wraparound.
- On the first tick of the step (px_cnt 0->1) and at px_cnt==STEP_PX/2, Anim_Phase<=Anim_Phase+1 mod 4.

BUMP:
- Same tick, counter and Anim_Phase rules as WALK, but Map_X/Map_Y are held.
- step_done is not asserted.

End of step (px_cnt reaches STEP_PX):
- Chain: if key_valid and key_dir==Direction and blocked==0, start the next WALK in the same cycle, with no idle tick. Anim_Phase continues the 0->1->2->3 sequence.
- Otherwise go to IDLE; Anim_Phase<=0 if odd, else hold.

Other rules:
- key_dir and key_valid changes during WALK/BUMP are ignored until the step ends. A step always completes a whole tile.
- blocked is sampled only at step start. A change mid-step has no effect.
- With no frame_tick, the block is fully static.

Optional Feature:
Macro WALK_RUN_EN.
- Defined:
  - Adds input key_run (1 bit), sampled at step start and held for the whole step.
  - If set, WALK/BUMP advance 2 px per tick and the step ends after STEP_PX/2 ticks.
  - Anim_Phase advances on the first tick and at px_cnt==STEP_PX/2 in pixels (tick STEP_PX/4).
- Undefined: no key_run port; 1 px per tick always.

Test Plan:
- Turn then walk: Reset, Direction=0. Hold key_dir=1 unblocked, pulse frame_tick.
  - Expect: Direction=1, 4 ticks in TURN with Map_X=0, then 16 WALK ticks, Map_X=16, single step_done pulse.
  - Expect Anim_Phase sequence 1 (tick 1), 2 (tick 8), then 2 in IDLE.
- Continuous walk: hold key_dir=2 (facing down) for 40 ticks.
  - Expect Map_Y=32 after two chained steps, no idle gap, Anim_Phase reaching 0 after the second step, two step_done pulses.
- Blocked: facing up, blocked=1, hold key.
  - Expect BUMP, Character_Moving=1 for 16 ticks, Map_Y unchanged, no step_done, then re-BUMP while held.
- Early release: start a WALK left from Map_X=0, release the key at tick 3.
  - Expect the step to finish with Map_X=1008 (wrap), then IDLE.
- Reset mid-step: assert Reset at tick 7 of a WALK right from START_X=100.
  - Expect next cycle Map_X=100, IDLE, Direction=0, Anim_Phase=0, Character_Moving=0.
- No tick: hold the key with frame_tick=0 for 1000 Clk.
  - Expect all outputs unchanged.
